// File: rtl/pll_reg_bank_if.sv
// pll_reg_bank_if
// Byte-transaction bus between the SPI slave and the PLL register bank.
//   rw           1 = write, 0 = read (qualified by valid)
//   valid        single-cycle transaction strobe
//   addr_to_reg  register address (AW bits)
//   data_to_reg  write data (DW bits)
//   data_in_reg  read data returned by the register bank (DW bits)
//   rd_valid     one-cycle pulse marking an updated data_in_reg
// Modports: master = SPI slave side, slave = register bank side.
interface pll_reg_bank_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    logic          rw;
    logic          valid;
    logic [AW-1:0] addr_to_reg;
    logic [DW-1:0] data_to_reg;
    logic [DW-1:0] data_in_reg;
    logic          rd_valid;

    modport master (
        output rw, valid, addr_to_reg, data_to_reg,
        input  data_in_reg, rd_valid
    );

    modport slave (
        input  rw, valid, addr_to_reg, data_to_reg,
        output data_in_reg, rd_valid
    );
endinterface

// File: rtl/pll_reg_bank.sv
// pll_reg_bank
// Multi-channel PLL register bank. Each channel c owns four registers at
// base 4*c: DCO_TST (RW), DIV_SHADOW (RW), ENABLE (RW), DCO_STS (RO).
// Two global registers sit at the top of the address space:
// UPD_FLAGS (sticky, write-one-to-clear) and APPLY (write-only, copies
// the selected shadow dividers into the active dividers).
// Ports:
//   clk, rst     single clock, asynchronous active-high reset
//   bus          register bus, slave side (see pll_reg_bank_if)
//   dco_tst_reg  per-channel DCO test words, channel c at [c*DW +: DW]
//   div_reg      per-channel active divider values
//   div_en1/2    per-channel divider enables (ENABLE bits 0 and 1)
//   dco_upd      per-channel status capture strobes
//   dco_sts      per-channel DCO status words
//   upd_irq      OR of all update flags
module pll_reg_bank #(
    parameter int NUM_CH = 4,
    parameter int DW     = 8,
    parameter int AW     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    pll_reg_bank_if.slave        bus,
    output logic [NUM_CH*DW-1:0] dco_tst_reg,
    output logic [NUM_CH*DW-1:0] div_reg,
    output logic [NUM_CH-1:0]    div_en1,
    output logic [NUM_CH-1:0]    div_en2,
    input  logic [NUM_CH-1:0]    dco_upd,
    input  logic [NUM_CH*DW-1:0] dco_sts,
    output logic                 upd_irq
);

    localparam logic [AW-1:0] FLAGS_ADDR = AW'(2**AW - 2);
    localparam logic [AW-1:0] APPLY_ADDR = '1;
    localparam logic [DW-1:0] ENABLE_RST = DW'(3);

    logic          wr_stb;
    logic          rd_stb;
    logic [AW-3:0] addr_ch;
    logic [1:0]    addr_off;
    logic          flags_wr;
    logic          apply_wr;

    assign wr_stb   = bus.valid & bus.rw;
    assign rd_stb   = bus.valid & ~bus.rw;
    assign addr_ch  = bus.addr_to_reg[AW-1:2];
    assign addr_off = bus.addr_to_reg[1:0];
    assign flags_wr = wr_stb && (bus.addr_to_reg == FLAGS_ADDR);
    assign apply_wr = wr_stb && (bus.addr_to_reg == APPLY_ADDR);

    logic [DW-1:0]     ch_rd_data [NUM_CH];
    logic [NUM_CH-1:0] flags;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [AW-3:0] CH = (AW-2)'(gi);

            logic [DW-1:0] tst_reg;
            logic [DW-1:0] shadow_reg;
            logic [DW-1:0] enable_reg;
            logic [DW-1:0] sts_reg;
            logic [DW-1:0] div_act_reg;
            logic          flag_reg;
            logic          ch_wr;

            // Global addresses never alias a channel because 4*NUM_CH <= 2^AW-2.
            assign ch_wr = wr_stb && (addr_ch == CH);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tst_reg     <= '0;
                    shadow_reg  <= '0;
                    enable_reg  <= ENABLE_RST;
                    sts_reg     <= '0;
                    div_act_reg <= '0;
                    flag_reg    <= 1'b0;
                end else begin
                    if (ch_wr && addr_off == 2'd0) tst_reg    <= bus.data_to_reg;
                    if (ch_wr && addr_off == 2'd1) shadow_reg <= bus.data_to_reg;
                    if (ch_wr && addr_off == 2'd2) enable_reg <= bus.data_to_reg;
                    if (dco_upd[gi]) sts_reg <= dco_sts[gi*DW +: DW];
                    // Shadow is read before this edge, so a pending shadow
                    // value is what reaches the active divider.
                    if (apply_wr && bus.data_to_reg[gi]) div_act_reg <= shadow_reg;
                    // A capture strobe beats a simultaneous clear.
                    if (dco_upd[gi])
                        flag_reg <= 1'b1;
                    else if (flags_wr && bus.data_to_reg[gi])
                        flag_reg <= 1'b0;
                end
            end

            assign ch_rd_data[gi] = (addr_off == 2'd0) ? tst_reg    :
                                    (addr_off == 2'd1) ? shadow_reg :
                                    (addr_off == 2'd2) ? enable_reg : sts_reg;

            assign flags[gi]                 = flag_reg;
            assign dco_tst_reg[gi*DW +: DW]  = tst_reg;
            assign div_reg[gi*DW +: DW]      = div_act_reg;
            assign div_en1[gi]               = enable_reg[0];
            assign div_en2[gi]               = enable_reg[1];
        end
    endgenerate

    assign upd_irq = |flags;

    // Read mux: APPLY, unmapped addresses and channels >= NUM_CH fall through to 0.
    logic [DW-1:0] rd_data_next;
    always_comb begin
        rd_data_next = '0;
        if (bus.addr_to_reg == FLAGS_ADDR) begin
            rd_data_next = DW'(flags);
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (addr_ch == (AW-2)'(c)) rd_data_next = ch_rd_data[c];
            end
        end
    end

    logic [DW-1:0] rd_data_reg;
    logic          rd_valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_stb;
            if (rd_stb) rd_data_reg <= rd_data_next;
        end
    end

    assign bus.data_in_reg = rd_data_reg;
    assign bus.rd_valid    = rd_valid_reg;

endmodule

// File: tb/tb_pll_reg_bank.sv
// tb_pll_reg_bank
// Scoreboard bench for pll_reg_bank (NUM_CH=4, DW=8, AW=5). Reads push the
// expected data into a queue; a monitor pops and compares on every rd_valid.
// Side-band outputs (div_reg, enables, irq) are checked directly.
module tb_pll_reg_bank;
    localparam int NUM_CH = 4;
    localparam int DW     = 8;
    localparam int AW     = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pll_reg_bank_if #(.AW(AW), .DW(DW)) bus ();

    logic [NUM_CH*DW-1:0] dco_tst_reg;
    logic [NUM_CH*DW-1:0] div_reg;
    logic [NUM_CH-1:0]    div_en1;
    logic [NUM_CH-1:0]    div_en2;
    logic [NUM_CH-1:0]    dco_upd;
    logic [NUM_CH*DW-1:0] dco_sts;
    logic                 upd_irq;

    pll_reg_bank #(.NUM_CH(NUM_CH), .DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dco_tst_reg (dco_tst_reg),
        .div_reg     (div_reg),
        .div_en1     (div_en1),
        .div_en2     (div_en2),
        .dco_upd     (dco_upd),
        .dco_sts     (dco_sts),
        .upd_irq     (upd_irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } rd_exp_t;

    rd_exp_t sb_q[$];

    always @(negedge clk) begin : mon
        rd_exp_t e;
        if (!rst && bus.rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("rd addr=%0d data=0x%02h exp=0x%02h", e.addr, bus.data_in_reg, e.exp);
                check("rd_data", 32'(bus.data_in_reg), 32'(e.exp));
            end
        end
    end

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.rw = 1'b1;
        bus.addr_to_reg = a;
        bus.data_to_reg = d;
        $display("wr addr=%0d data=0x%02h", a, d);
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    task automatic rd_issue(input logic [AW-1:0] a, input logic [DW-1:0] e);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.rw = 1'b0;
        bus.addr_to_reg = a;
        sb_q.push_back('{addr: a, exp: e});
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
        rd_issue(a, e);
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    task automatic upd_pulse(input logic [NUM_CH-1:0] m, input logic [NUM_CH*DW-1:0] s);
        @(negedge clk);
        dco_upd = m;
        dco_sts = s;
        $display("upd mask=%b sts=0x%08h", m, s);
        @(negedge clk);
        dco_upd = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid = 1'b0;
        bus.rw = 1'b0;
        bus.addr_to_reg = '0;
        bus.data_to_reg = '0;
        dco_upd = '0;
        dco_sts = '0;

        // Reset state
        #7;
        check("rst_div_en1", 32'(div_en1), 32'hF);
        check("rst_div_en2", 32'(div_en2), 32'hF);
        check("rst_upd_irq", 32'(upd_irq), 32'd0);
        check("rst_div_reg", div_reg, 32'd0);
        check("rst_dco_tst", dco_tst_reg, 32'd0);
        check("rst_data_in", 32'(bus.data_in_reg), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // All 18 mapped addresses, back-to-back
        for (int c = 0; c < NUM_CH; c++)
            for (int o = 0; o < 4; o++)
                rd_issue(AW'(c*4 + o), (o == 2) ? 8'h03 : 8'h00);
        rd_issue(5'd30, 8'h00);
        rd_issue(5'd31, 8'h00);
        @(negedge clk);
        bus.valid = 1'b0;

        // Shadow then APPLY
        wr(5'd5, 8'h2A);
        rd(5'd5, 8'h2A);
        check("shadow_no_apply", 32'(div_reg[15:8]), 32'h00);
        wr(5'd31, 8'h02);
        check("apply_ch1", div_reg, 32'h00002A00);

        wr(5'd8, 8'h77);
        check("dco_tst_ch2", dco_tst_reg, 32'h00770000);
        wr(5'd14, 8'h01);
        check("en1_ch3", 32'(div_en1), 32'hF);
        check("en2_ch3", 32'(div_en2), 32'h7);
        rd(5'd14, 8'h01);

        // Status capture and W1C
        upd_pulse(4'b0100, 32'h005C_0000);
        check("irq_set", 32'(upd_irq), 32'd1);
        rd(5'd11, 8'h5C);
        rd(5'd30, 8'h04);
        wr(5'd30, 8'h04);
        check("irq_clr", 32'(upd_irq), 32'd0);
        rd(5'd30, 8'h00);

        // Read of DCO_STS in the capture cycle returns the old value
        @(negedge clk);
        bus.valid = 1'b1;
        bus.rw = 1'b0;
        bus.addr_to_reg = 5'd11;
        dco_upd = 4'b0100;
        dco_sts[23:16] = 8'h99;
        sb_q.push_back('{addr: 5'd11, exp: 8'h5C});
        @(negedge clk);
        bus.valid = 1'b0;
        dco_upd = '0;
        rd(5'd11, 8'h99);
        wr(5'd30, 8'h04);

        // Capture beats simultaneous W1C
        @(negedge clk);
        bus.valid = 1'b1;
        bus.rw = 1'b1;
        bus.addr_to_reg = 5'd30;
        bus.data_to_reg = 8'h01;
        dco_upd = 4'b0001;
        dco_sts[7:0] = 8'h33;
        @(negedge clk);
        bus.valid = 1'b0;
        dco_upd = '0;
        check("irq_w1c_race", 32'(upd_irq), 32'd1);
        rd(5'd30, 8'h01);
        wr(5'd30, 8'h01);
        rd(5'd30, 8'h00);
        check("irq_after_clr", 32'(upd_irq), 32'd0);

        // RO and unmapped writes ignored
        wr(5'd3, 8'hFF);
        wr(5'd20, 8'hFF);
        rd(5'd3, 8'h33);
        rd(5'd20, 8'h00);
        check("div_unchanged", div_reg, 32'h00002A00);
        check("tst_unchanged", dco_tst_reg, 32'h00770000);

        // Reset between shadow write and APPLY
        upd_pulse(4'b0010, dco_sts);
        check("irq_pre_rst", 32'(upd_irq), 32'd1);
        wr(5'd1, 8'h10);
        rd(5'd1, 8'h10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst2_div_reg", div_reg, 32'd0);
        check("rst2_dco_tst", dco_tst_reg, 32'd0);
        check("rst2_div_en1", 32'(div_en1), 32'hF);
        check("rst2_div_en2", 32'(div_en2), 32'hF);
        check("rst2_upd_irq", 32'(upd_irq), 32'd0);
        check("rst2_data_in", 32'(bus.data_in_reg), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd(5'd1, 8'h00);
        wr(5'd31, 8'h01);
        check("apply_after_rst", 32'(div_reg[7:0]), 32'h00);
        rd(5'd8, 8'h00);
        rd(5'd14, 8'h03);
        rd(5'd30, 8'h00);
        rd(5'd11, 8'h00);

        // Multi-channel APPLY on one edge
        wr(5'd1, 8'h11);
        wr(5'd5, 8'h22);
        wr(5'd13, 8'h44);
        check("multi_pre_apply", div_reg, 32'd0);
        wr(5'd31, 8'h0B);
        check("multi_apply", div_reg, 32'h44002211);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pll_reg_bank.md
# pll_reg_bank

Parametrised SPI-facing register bank for the multi-channel PLL. It replaces the single-channel register block with NUM_CH identical channel register sets, read-only DCO status capture, sticky write-one-to-clear update flags, and double-buffered divider values that change only on an explicit apply. It sits between the SPI slave (byte transactions: rw, valid, address, data) and the per-channel DCO/divider datapaths.

## Interface
- NUM_CH, 4: number of PLL channels, 1..4.
- DW, 8: register data width.
- AW, 5: address width; 4*NUM_CH must be at most 2^AW-2.

- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- rw  in  1  1 = write, 0 = read; sampled only when valid=1.
- valid  in  1  single-cycle transaction strobe from the SPI slave.
- addr_to_reg  in  AW  register address.
- data_to_reg  in  DW  write data.
- data_in_reg  out  DW  read data returned to the SPI slave.
- rd_valid  out  1  one-cycle pulse; data_in_reg is updated.
- dco_tst_reg  out  NUM_CH*DW  per-channel DCO test word; channel c occupies bits [c*DW +: DW].
- div_reg  out  NUM_CH*DW  per-channel active divider value.
- div_en1  out  NUM_CH  per-channel divider enable 1 (ENABLE bit 0).
- div_en2  out  NUM_CH  per-channel divider enable 2 (ENABLE bit 1).
- dco_upd  in  NUM_CH  per-channel status-capture strobe, synchronous to clk.
- dco_sts  in  NUM_CH*DW  per-channel DCO status word.
- upd_irq  out  1  OR of all UPD_FLAGS bits.

## Operation
- Address map, channel c at base 4*c: +0 DCO_TST (RW), +1 DIV_SHADOW (RW), +2 ENABLE (RW), +3 DCO_STS (RO).
- Global: 2^AW-2 = UPD_FLAGS (bit c sticky, W1C; bits >= NUM_CH read 0). 2^AW-1 = APPLY (write-only; bit c=1 copies DIV_SHADOW[c] to active div_reg[c]; reads 0).
- Write (valid=1, rw=1): the addressed RW register loads data_to_reg. Writes to RO, unmapped, or channel >= NUM_CH addresses are ignored.
- Read (valid=1, rw=0): data_in_reg loads the addressed value. Unmapped addresses return 0. DIV_SHADOW reads return the shadow, not the active value. data_in_reg holds its value until the next read.
- Status capture: dco_upd[c]=1 loads DCO_STS[c] from dco_sts[c] and sets UPD_FLAGS[c].
- W1C: a write to UPD_FLAGS clears each bit c where data_to_reg[c]=1. A simultaneous dco_upd[c] wins, and the bit stays set.
- An APPLY with multiple bits set updates all of those channels on the same edge. A DIV_SHADOW write does not affect div_reg until APPLY.
- Reset values: DCO_TST 0, DIV_SHADOW 0, div_reg 0, ENABLE 0x03 (div_en1 = div_en2 = all ones), DCO_STS 0, UPD_FLAGS 0, data_in_reg 0, rd_valid 0, upd_irq 0.
- Reset assertion at any point, including between shadow write and APPLY, returns all state to reset values immediately. Pending shadow values are lost.

## Timing
- All state updates on the rising clk edge where the qualifying input is high. Outputs are registered and reflect a write from the following cycle.
- Read latency is 1: a read sampled at edge N gives data_in_reg and rd_valid=1 after edge N. rd_valid returns to 0 after edge N+1 unless another read occurs.
- Back-to-back reads on consecutive cycles are supported; rd_valid stays high and data updates every cycle.
- A read of DCO_STS or UPD_FLAGS in the same cycle as dco_upd returns the pre-update value.
- Reading a register in the cycle after a write to it returns the new value.
- APPLY: div_reg[c] changes on the edge that samples the APPLY write, using the shadow value registered before that edge.
- upd_irq is combinational from the UPD_FLAGS registers only, so it is effectively registered. It rises the cycle after dco_upd and falls the cycle after the clearing W1C.

## Test plan
- Reset with NUM_CH=4: read all 18 mapped addresses -> ENABLE reads 0x03, all others 0; div_en1 = div_en2 = 4'b1111; upd_irq=0.
- Write 0x2A to address 5 (ch1 DIV_SHADOW) -> read returns 0x2A and div_reg[15:8] stays 0x00. Write 0x02 to address 31 -> div_reg[15:8]=0x2A next cycle; other channels unchanged.
- Pulse dco_upd=4'b0100 with dco_sts[23:16]=0x5C -> address 11 reads 0x5C, UPD_FLAGS=0x04, upd_irq=1. Write 0x04 to address 30 -> UPD_FLAGS=0, upd_irq=0.
- W1C of 0x01 to address 30 in the same cycle as dco_upd[0] -> UPD_FLAGS[0] stays 1.
- Write 0xFF to address 3 (RO) and to address 20 (unmapped) -> no state change; read of address 20 returns 0x00 with rd_valid pulsed.
- Write DIV_SHADOW 0x10 on ch0, then assert rst before APPLY -> div_reg[7:0]=0 and shadow=0. A later APPLY of 0x01 keeps div_reg[7:0]=0.
